// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the digit-serial BCD arithmetic datapaths.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bcd_t       BCD_MAX        = 4'd9;
    localparam logic [4:0] BCD_BASE       = 5'd10;
    localparam bcd_t       BCD_ERR_NIBBLE = 4'hF;

    function automatic logic is_bcd(input bcd_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: digit = (a+b+cin) mod 10, cout when the raw sum exceeds 9.
// Latency: combinational. Backpressure: none.
// Non-BCD inputs give a deterministic but meaningless digit.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    output bcd_t digit,
    output logic cout
);

    logic [4:0] sum_raw;

    always_comb begin
        sum_raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout    = sum_raw > {1'b0, BCD_MAX};
        // Subtracting 10 modulo 16 gives the same low nibble as the 5-bit s-10.
        digit   = cout ? (sum_raw[3:0] - BCD_BASE[3:0]) : sum_raw[3:0];
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder, LSD first through a carry flop; optional INPUT_CHECK_EN adds err.
// Latency: start at edge k -> busy k+1..k+NUM_DIGITS, done pulse in cycle k+NUM_DIGITS+1.
// Backpressure: none; start is only sampled in IDLE/DONE, ignored (not queued) while busy.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [4*NUM_DIGITS-1:0]   a_digits,
    input  logic [4*NUM_DIGITS-1:0]   b_digits,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS+3:0]   sum_digits
`ifdef INPUT_CHECK_EN
    ,
    output logic                      err
`endif
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int OP_W  = 4 * NUM_DIGITS;
    localparam int SUM_W = OP_W + 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t             state_q, state_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [OP_W-1:0]    work_q, work_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    bcd_t               add_digit;
    logic               add_cout;

`ifdef INPUT_CHECK_EN
    logic               err_q, err_d;

    function automatic logic any_invalid(input logic [OP_W-1:0] v);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!is_bcd(v[4*i +: 4])) return 1'b1;
        end
        return 1'b0;
    endfunction
`endif

    // Operands shift right each ADD cycle, so the current digit is always in [3:0].
    bcd_digit_add u_digit_add (
        .a     (a_q[3:0]),
        .b     (b_q[3:0]),
        .cin   (carry_q),
        .digit (add_digit),
        .cout  (add_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
`ifdef INPUT_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a_digits;
                    b_d     = b_digits;
                    work_d  = '0;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ADD;
`ifdef INPUT_CHECK_EN
                    err_d   = 1'b0;
                    if (any_invalid(a_digits) || any_invalid(b_digits)) begin
                        err_d   = 1'b1;
                        sum_d   = {(NUM_DIGITS + 1){BCD_ERR_NIBBLE}};
                        state_d = DONE;
                    end
`endif
                end
            end
            ADD: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = add_cout;
                idx_d   = idx_q + IDX_W'(1);
                work_d[{idx_q, 2'b00} +: 4] = add_digit;
                if (idx_q == LAST_IDX) begin
                    sum_d   = {3'b000, add_cout, work_d};
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ADD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef INPUT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef INPUT_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sum_digits = sum_q;
`ifdef INPUT_CHECK_EN
    assign err        = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed table, corner sequences, random BCD sums.
module tb_bcd_serial_adder;

    localparam int N     = 2;
    localparam int OP_W  = 4 * N;
    localparam int SUM_W = OP_W + 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [OP_W-1:0]  a_in  = '0;
    logic [OP_W-1:0]  b_in  = '0;
    logic             busy;
    logic             done;
    logic [SUM_W-1:0] sum;
`ifdef INPUT_CHECK_EN
    logic             err;
`endif

    int               checks = 0;
    int               errors = 0;
    logic [SUM_W-1:0] prev_sum = '0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.NUM_DIGITS(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_digits   (a_in),
        .b_digits   (b_in),
        .busy       (busy),
        .done       (done),
        .sum_digits (sum)
`ifdef INPUT_CHECK_EN
        ,
        .err        (err)
`endif
    );

    typedef struct {
        logic [OP_W-1:0]  a;
        logic [OP_W-1:0]  b;
        logic [SUM_W-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decimal value of the operands, plain integer add, back to BCD.
    function automatic int bcd_val(input logic [OP_W-1:0] v);
        int r = 0;
        for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [SUM_W-1:0] to_bcd(input int x);
        logic [SUM_W-1:0] r = '0;
        int               t = x;
        for (int i = 0; i <= N; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Called at a negedge; drives start, then checks every cycle up to the done pulse.
    task automatic do_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                         input logic [SUM_W-1:0] exp, input bit glitch);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = glitch;
        a_in  = OP_W'($urandom);
        b_in  = OP_W'($urandom);
        for (int c = 1; c <= N; c++) begin
            chk("busy_during_add", 32'(busy), 32'd1);
            chk("done_during_add", 32'(done), 32'd0);
            chk("sum_held_during_add", 32'(sum), 32'(prev_sum));
`ifdef INPUT_CHECK_EN
            chk("err_during_add", 32'(err), 32'd0);
`endif
            @(negedge clk);
            start = 1'b0;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("sum_at_done", 32'(sum), 32'(exp));
        prev_sum = exp;
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("done_after_pulse", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("sum_held_idle", 32'(sum), 32'(prev_sum));
    endtask

    initial begin
        logic [OP_W-1:0] ra, rb;

        vecs[0] = '{a: 8'h47, b: 8'h38, exp: 12'h085};
        vecs[1] = '{a: 8'h99, b: 8'h99, exp: 12'h198};
        vecs[2] = '{a: 8'h00, b: 8'h00, exp: 12'h000};
        vecs[3] = '{a: 8'h50, b: 8'h50, exp: 12'h100};
        vecs[4] = '{a: 8'h09, b: 8'h01, exp: 12'h010};
        vecs[5] = '{a: 8'h81, b: 8'h19, exp: 12'h100};

        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
`ifdef INPUT_CHECK_EN
        chk("reset_err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
            idle_chk();
        end

        // Back-to-back: second start issued during the DONE cycle of the first.
        do_op(8'h99, 8'h01, 12'h100, 1'b0);
        do_op(8'h15, 8'h27, 12'h042, 1'b0);
        idle_chk();

        // start re-asserted while busy with other operands must be ignored.
        do_op(8'h23, 8'h45, 12'h068, 1'b1);
        idle_chk();

        // Reset during the first ADD cycle discards the operation.
        start = 1'b1;
        a_in  = 8'h58;
        b_in  = 8'h67;
        @(negedge clk);
        start = 1'b0;
        chk("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_busy", 32'(busy), 32'd0);
        chk("midop_reset_done", 32'(done), 32'd0);
        chk("midop_reset_sum", 32'(sum), 32'd0);
        prev_sum = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle_chk();
        do_op(8'h58, 8'h67, 12'h125, 1'b0);
        idle_chk();

        for (int i = 0; i < 30; i++) begin
            for (int d = 0; d < N; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            do_op(ra, rb, to_bcd(bcd_val(ra) + bcd_val(rb)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_chk();
        end

`ifdef INPUT_CHECK_EN
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'h3A;
        b_in  = 8'h10;
        @(negedge clk);
        start = 1'b0;
        chk("bad_digit_busy", 32'(busy), 32'd0);
        chk("bad_digit_done", 32'(done), 32'd1);
        chk("bad_digit_err", 32'(err), 32'd1);
        chk("bad_digit_sum", 32'(sum), 32'hFFF);
        prev_sum = 12'hFFF;
        idle_chk();
        chk("err_sticky", 32'(err), 32'd1);
        do_op(8'h12, 8'h34, 12'h046, 1'b0);
        chk("err_cleared", 32'(err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
